// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and slice function select for the
// nibble-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FN_AND   = 2'b00,
        FN_OR    = 2'b01,
        FN_ARITH = 2'b10,
        FN_ZERO  = 2'b11
    } slice_func_t;

    // Reserved op codes map to FN_ZERO so the slice output is forced low.
    function automatic slice_func_t decode_op(input logic [2:0] op);
        case (op)
            OP_AND:                 return FN_AND;
            OP_OR:                  return FN_OR;
            OP_ADD, OP_SUB, OP_SLT: return FN_ARITH;
            default:                return FN_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit AND/OR/ADD slice with optional B inversion, carry
// chaining and a tap on the MSB of the sum.
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  slice_func_t func,
    input  logic        binvert,
    input  logic        cin,
    output logic [3:0]  y,
    output logic        cout,
    output logic        sum_msb
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    assign b_eff   = b ^ {4{binvert}};
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    assign cout    = sum[4];
    assign sum_msb = sum[3];

    always_comb begin
        y = 4'h0;
        case (func)
            FN_AND:   y = a & b;
            FN_OR:    y = a | b;
            FN_ARITH: y = sum[3:0];
            default:  y = 4'h0;
        endcase
    end

endmodule

// File: rtl/nibble_serial_alu.sv
// Multi-cycle ALU: streams operands one nibble per cycle (LSB first) through a
// single 4-bit slice, with valid/ready handshakes on input and result.
module nibble_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output state_t           dbg_state
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_reg;
    logic [CNT_W-1:0] nib_cnt;
    logic             carry_reg;

    logic [3:0]       slice_y;
    logic             slice_cout, slice_msb;
    logic             accept, last_nib, is_arith, ovf_raw;
    logic [WIDTH-1:0] res_next, res_final;

    alu_nibble_slice u_slice (
        .a       (a_sh[3:0]),
        .b       (b_sh[3:0]),
        .func    (decode_op(op_reg)),
        .binvert (op_reg[2]),
        .cin     (carry_reg),
        .y       (slice_y),
        .cout    (slice_cout),
        .sum_msb (slice_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (nib_cnt == LAST_NIB) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign last_nib  = (state == RUN) && (nib_cnt == LAST_NIB);
    assign is_arith  = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_SLT);
    // Only meaningful on the final nibble, where a_sh/b_sh hold the top nibble.
    assign ovf_raw   = (a_sh[3] ^ (b_sh[3] ^ op_reg[2]) ^ 1'b1) & (a_sh[3] ^ slice_msb);

    always_comb begin
        res_next = result;
        res_next[4*nib_cnt +: 4] = slice_y;
        res_final = res_next;
        case (op_reg)
            OP_AND, OP_OR, OP_ADD, OP_SUB: res_final = res_next;
            OP_SLT:  res_final = {{(WIDTH-1){1'b0}}, slice_msb ^ ovf_raw};
            default: res_final = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            op_reg    <= OP_AND;
            nib_cnt   <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= b;
            op_reg    <= op;
            nib_cnt   <= '0;
            carry_reg <= op[2];
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (state == RUN) begin
            a_sh      <= a_sh >> 4;
            b_sh      <= b_sh >> 4;
            nib_cnt   <= nib_cnt + 1'b1;
            carry_reg <= slice_cout;
            if (last_nib) begin
                result   <= res_final;
                cout     <= is_arith ? slice_cout : 1'b0;
                overflow <= ((op_reg == OP_ADD) || (op_reg == OP_SUB)) ? ovf_raw : 1'b0;
                zero     <= (res_final == '0);
            end else begin
                result   <= res_next;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Randomised and directed checks of nibble_serial_alu (WIDTH=16) against a
// whole-word arithmetic reference model.
module tb_nibble_serial_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout, overflow, zero;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;

    nibble_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, signed compare for SLT.
    task automatic model(input logic [2:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         output logic [W-1:0] r, output logic c, output logic v, output logic z);
        logic [W:0] s;
        r = '0; c = 1'b0; v = 1'b0;
        case (op_v)
            OP_AND: r = a_v & b_v;
            OP_OR:  r = a_v | b_v;
            OP_ADD: begin
                s = {1'b0, a_v} + {1'b0, b_v};
                r = s[W-1:0]; c = s[W];
                v = (a_v[W-1] == b_v[W-1]) && (r[W-1] != a_v[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a_v} + {1'b0, ~b_v} + 1;
                r = s[W-1:0]; c = s[W];
                v = (a_v[W-1] != b_v[W-1]) && (r[W-1] != a_v[W-1]);
            end
            OP_SLT: begin
                s = {1'b0, a_v} + {1'b0, ~b_v} + 1;
                c = s[W];
                r = ($signed(a_v) < $signed(b_v)) ? 1 : 0;
            end
            default: ;
        endcase
        z = (r == '0);
    endtask

    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic [2:0] op_v, input int hold);
        logic [W-1:0] er;
        logic ec, ev, ez;
        int lat;
        model(op_v, a_v, b_v, er, ec, ev, ez);
        @(negedge clk);
        a = a_v; b = b_v; op = op_v; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        out_ready = 1'b1;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= 2) out_ready = 1'b0;
            if (k == 1) check("busy_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd4);
        if (lat < 0) return;
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("overflow", 32'(overflow), 32'(ev));
        check("zero", 32'(zero), 32'(ez));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(er));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_flags"}, {29'd0, cout, overflow, zero}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } vec_t;

    vec_t dir[12];

    initial begin
        dir[0]  = '{16'h7FFF, 16'h0001, OP_ADD};
        dir[1]  = '{16'h0005, 16'h0005, OP_SUB};
        dir[2]  = '{16'hFFFF, 16'h0001, OP_ADD};
        dir[3]  = '{16'hFFFF, 16'h0001, OP_SLT};
        dir[4]  = '{16'h8000, 16'h7FFF, OP_SLT};
        dir[5]  = '{16'h0001, 16'hFFFF, OP_SLT};
        dir[6]  = '{16'hF0F0, 16'hFF00, OP_AND};
        dir[7]  = '{16'hF0F0, 16'hFF00, OP_OR};
        dir[8]  = '{16'h1234, 16'h5678, 3'b011};
        dir[9]  = '{16'h8000, 16'h0001, OP_SUB};
        dir[10] = '{16'h7FFF, 16'h7FFF, OP_SLT};
        dir[11] = '{16'h0F0F, 16'hF0F1, OP_ADD};

        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].op, (i == 0) ? 3 : int'(i % 2));

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            logic [2:0] rop;
            logic [W-1:0] corner[4];
            corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rop = 3'($urandom_range(0, 7));
            run_op(ra, rb, rop, $urandom_range(0, 3));
        end

        // Abort mid-operation while the third nibble is being processed.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; op = OP_ADD; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_valid", 32'(out_valid), 32'd0);
        run_op(16'h1234, 16'h4321, OP_SUB, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
